// File: rtl/fp_finv.sv
// fp_finv: pipelined binary32 reciprocal, 4-cycle latency, seed/slope ROM plus linear interpolation.
// Build option FINV_SPECIAL_EN adds IEEE inf/NaN handling in the output stage.
module fp_finv #(
  parameter int TBL_BITS = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  output logic [31:0] y
);

  localparam int N_ENT   = 1 << TBL_BITS;
  localparam int MLOW_W  = 23 - TBL_BITS;
  localparam int SLOPE_W = 31 - TBL_BITS;
  localparam int PROD_W  = SLOPE_W + MLOW_W;

  // Q0.30 seed: chord start lowered by half the chord's worst-case bulge (minimax fit)
  function automatic logic [29:0] seed_at(input int i);
    longint unsigned xs, v, c;
    xs = (64'd1 << TBL_BITS) + 64'(i);
    v  = ((64'd1 << (30 + TBL_BITS)) + (xs >> 1)) / xs;
    c  = ((64'd1 << (27 + TBL_BITS)) + ((xs * xs * xs) >> 1)) / (xs * xs * xs);
    return 30'(v - c);
  endfunction

  function automatic logic [SLOPE_W-1:0] slope_at(input int i);
    longint unsigned xs, p, d;
    xs = (64'd1 << TBL_BITS) + 64'(i);
    p  = xs * (xs + 64'd1);
    d  = ((64'd1 << (30 + TBL_BITS)) + (p >> 1)) / p;
    return SLOPE_W'(d);
  endfunction

  logic [29:0]        seed_rom  [N_ENT];
  logic [SLOPE_W-1:0] slope_rom [N_ENT];

  for (genvar g = 0; g < N_ENT; g++) begin : g_rom
    assign seed_rom[g]  = seed_at(g);
    assign slope_rom[g] = slope_at(g);
  end

  logic [TBL_BITS-1:0] idx;
  logic                s1_v, s1_sign, s1_mzero;
  logic [7:0]          s1_exp;
  logic [29:0]         s1_seed;
  logic [SLOPE_W-1:0]  s1_slope;
  logic [MLOW_W-1:0]   s1_mlow;

  logic [SLOPE_W-1:0]  drop;
  logic                s2_v, s2_sign, s2_mzero;
  logic [7:0]          s2_exp;
  logic [29:0]         s2_r;

  logic                norm, guard_n, sticky_n;
  logic [9:0]          e_res;
  logic [22:0]         frac_n;
  logic                s3_v, s3_sign, s3_zin, s3_guard, s3_sticky;
  logic [9:0]          s3_exp;
  logic [22:0]         s3_frac;
`ifdef FINV_SPECIAL_EN
  logic                s3_inf, s3_nan;
`endif

  logic                round_up, flush;
  logic [23:0]         mant_r;
  logic [9:0]          exp_f;
  logic [31:0]         y_next;

  assign idx  = x1[22 -: TBL_BITS];
  assign drop = SLOPE_W'(({{MLOW_W{1'b0}}, s1_slope} * {{SLOPE_W{1'b0}}, s1_mlow}) >> MLOW_W);

  // quotient sits in (0.5,1); the one-bit fallback shift only guards against seed undershoot
  always_comb begin
    norm     = s2_r[29];
    frac_n   = norm ? s2_r[28:6] : s2_r[27:5];
    guard_n  = norm ? s2_r[5] : s2_r[4];
    sticky_n = norm ? (|s2_r[4:0]) : (|s2_r[3:0]);
    if (s2_mzero) begin
      e_res    = 10'd254 - {2'b00, s2_exp};
      frac_n   = '0;
      guard_n  = 1'b0;
      sticky_n = 1'b0;
    end else if (norm) begin
      e_res = 10'd253 - {2'b00, s2_exp};
    end else begin
      e_res = 10'd252 - {2'b00, s2_exp};
    end
  end

  always_comb begin
    round_up = s3_guard & (s3_sticky | s3_frac[0]);
    mant_r   = {1'b0, s3_frac} + {23'd0, round_up};
    exp_f    = s3_exp + {9'd0, mant_r[23]};
    flush    = exp_f[9] | (exp_f == 10'd0);
    y_next   = {s3_sign, exp_f[7:0], mant_r[22:0]};
    if (flush)  y_next = {s3_sign, 31'd0};
    if (s3_zin) y_next = {s3_sign, 8'hFF, 23'd0};
`ifdef FINV_SPECIAL_EN
    if (s3_inf) y_next = {s3_sign, 31'd0};
    if (s3_nan) y_next = 32'h7FC0_0000;
`endif
    if (!s3_v)  y_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      s1_v      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mzero  <= 1'b0;
      s1_exp    <= '0;
      s1_seed   <= '0;
      s1_slope  <= '0;
      s1_mlow   <= '0;
      s2_v      <= 1'b0;
      s2_sign   <= 1'b0;
      s2_mzero  <= 1'b0;
      s2_exp    <= '0;
      s2_r      <= '0;
      s3_v      <= 1'b0;
      s3_sign   <= 1'b0;
      s3_zin    <= 1'b0;
      s3_exp    <= '0;
      s3_frac   <= '0;
      s3_guard  <= 1'b0;
      s3_sticky <= 1'b0;
`ifdef FINV_SPECIAL_EN
      s3_inf    <= 1'b0;
      s3_nan    <= 1'b0;
`endif
      y         <= '0;
    end else begin
      s1_v      <= 1'b1;
      s1_sign   <= x1[31];
      s1_exp    <= x1[30:23];
      s1_mzero  <= (x1[22:0] == 23'd0);
      s1_seed   <= seed_rom[idx];
      s1_slope  <= slope_rom[idx];
      s1_mlow   <= x1[MLOW_W-1:0];

      s2_v      <= s1_v;
      s2_sign   <= s1_sign;
      s2_exp    <= s1_exp;
      s2_mzero  <= s1_mzero;
      s2_r      <= s1_seed - {{(30 - SLOPE_W){1'b0}}, drop};

      s3_v      <= s2_v;
      s3_sign   <= s2_sign;
      s3_zin    <= (s2_exp == 8'd0);
      s3_exp    <= e_res;
      s3_frac   <= frac_n;
      s3_guard  <= guard_n;
      s3_sticky <= sticky_n;
`ifdef FINV_SPECIAL_EN
      s3_inf    <= (s2_exp == 8'hFF) & s2_mzero;
      s3_nan    <= (s2_exp == 8'hFF) & ~s2_mzero;
`endif

      y         <= y_next;
    end
  end

endmodule

// File: tb/tb_fp_finv.sv
// tb_fp_finv: per-cycle reference check of fp_finv against real-arithmetic 1/x with binary32 rounding.
module tb_fp_finv;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] x1;
  logic [31:0] y;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          v;
    logic [31:0] x;
  } ent_t;

  ent_t        hist[$];
  logic [31:0] dir_vec[$];

  localparam real MIN_NORM = 1.1754943508222875e-38;

  fp_finv #(.TBL_BITS(10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .x1   (x1),
    .y    (y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input int unsigned tol);
    logic [31:0] diff;
    total++;
    diff = (got > exp) ? got - exp : exp - got;
    if ((^got === 1'bx) || (diff > tol)) begin
      bad++;
      $display("FAIL %s: got %h, want %h (tol %0d ulp)", tag, got, exp, tol);
    end
  endtask

  function automatic real bits_to_real(input logic [31:0] b);
    real v;
    int  e;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    for (int i = 0; i < e; i++) v = v * 2.0;
    for (int i = 0; i > e; i--) v = v / 2.0;
    return b[31] ? -v : v;
  endfunction

  // nearest binary32 of a nonzero normal-range real
  function automatic logic [31:0] real_to_bits(input real r);
    real    a;
    int     k;
    longint f;
    a = (r < 0.0) ? -r : r;
    k = 0;
    while (a >= 2.0) begin a = a / 2.0; k++; end
    while (a < 1.0)  begin a = a * 2.0; k--; end
    f = longint'($floor((a - 1.0) * 8388608.0 + 0.5));
    if (f == 64'd8388608) begin f = 0; k++; end
    return {(r < 0.0), 8'(k + 127), 23'(f)};
  endfunction

  task automatic model(input logic [31:0] x, output logic [31:0] want,
                       output int unsigned tol, output bit skip);
    real r;
    skip = 1'b0;
    tol  = 0;
    want = '0;
    if (x[30:23] == 8'd0) begin
      want = {x[31], 8'hFF, 23'd0};
    end else if (x[30:23] == 8'hFF) begin
`ifdef FINV_SPECIAL_EN
      want = (x[22:0] == 23'd0) ? {x[31], 31'd0} : 32'h7FC0_0000;
`else
      skip = 1'b1;
`endif
    end else begin
      r = 1.0 / bits_to_real(x);
      if (((r < 0.0) ? -r : r) < MIN_NORM) begin
        want = {x[31], 31'd0};
      end else begin
        want = real_to_bits(r);
        tol  = (x[22:0] == 23'd0) ? 0 : 4;
      end
    end
  endtask

  // drive x/reset for one edge, then check y against the operand captured three edges earlier
  task automatic step(input logic [31:0] x, input bit rst, input string tag);
    ent_t        head;
    logic [31:0] want;
    int unsigned tol;
    bit          skip;
    x1   = x;
    rstn = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      hist.delete();
      repeat (4) hist.push_back('{v: 1'b0, x: 32'd0});
    end else begin
      hist.push_back('{v: 1'b1, x: x});
    end
    while (hist.size() > 4) void'(hist.pop_front());
    head = hist[0];
    if (!head.v) begin
      check({tag, " idle"}, y, 32'd0, 0);
    end else begin
      model(head.x, want, tol, skip);
      if (!skip) check($sformatf("%s x=%h", tag, head.x), y, want, tol);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic       s;
    logic [7:0] e;
    s = 1'($urandom_range(0, 1));
    e = 8'($urandom_range(1, 252));
    return {s, e, 23'($urandom)};
  endfunction

  initial begin
    x1   = '0;
    rstn = 1'b1;

    dir_vec.push_back(32'h3F80_0000);
    dir_vec.push_back(32'h4000_0000);
    dir_vec.push_back(32'hC080_0000);
    dir_vec.push_back(32'h4040_0000);
    dir_vec.push_back(32'h0000_0000);
    dir_vec.push_back(32'h8000_0000);
    dir_vec.push_back(32'h007F_FFFF);
    dir_vec.push_back(32'h7E80_0000);
    dir_vec.push_back(32'h7F00_0000);
    dir_vec.push_back(32'hFF00_0001);
    dir_vec.push_back(32'h3FFF_FFFF);
    dir_vec.push_back(32'h3F80_0001);
    dir_vec.push_back(32'h0080_0000);
    dir_vec.push_back(32'hBFC0_0000);
`ifdef FINV_SPECIAL_EN
    dir_vec.push_back(32'h7F80_0000);
    dir_vec.push_back(32'hFF80_0000);
    dir_vec.push_back(32'h7FC0_0001);
    dir_vec.push_back(32'hFFFF_FFFF);
`endif

    step(32'h3F80_0000, 1'b1, "reset");
    step(32'h4000_0000, 1'b1, "reset");

    foreach (dir_vec[i]) step(dir_vec[i], 1'b0, "dir");
    repeat (50) step(rand_op(), 1'b0, "rnd");

    step(rand_op(), 1'b1, "midrst");
    step(32'h4040_0000, 1'b0, "post");
    repeat (12) step(rand_op(), 1'b0, "post");
    repeat (4) step(32'h3F80_0000, 1'b0, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
